// File: rtl/sdram_init_param_if.sv
// Bus between the SDRAM init sequencer and the controller's command arbiter.
// The sequencer owns the command/address lines; the arbiter can request a re-init.
interface sdram_init_param_if #(
    parameter int ROW_W  = 13,
    parameter int BANK_W = 2
);
    logic              init_start;
    logic              init_busy;
    logic              init_end;
    logic [3:0]        init_cmd;
    logic [BANK_W-1:0] init_bank;
    logic [ROW_W-1:0]  init_addr;

    modport master (
        input  init_start,
        output init_busy, init_end, init_cmd, init_bank, init_addr
    );

    modport slave (
        output init_start,
        input  init_busy, init_end, init_cmd, init_bank, init_addr
    );
endinterface

// File: rtl/sdram_init_param.sv
// SDRAM power-up initialisation: NOP wait, precharge-all, N auto-refreshes, MRS, optional EMRS.
// Every timing is derived from the clock period; all bus outputs are registered.
module sdram_init_param #(
    parameter int               CLK_PERIOD_PS = 10000,
    parameter int               T_POWERUP_NS  = 200000,
    parameter int               T_RP_NS       = 20,
    parameter int               T_RFC_NS      = 70,
    parameter int               T_MRD_CYC     = 2,
    parameter int               AR_NUM        = 2,
    parameter int               ROW_W         = 13,
    parameter int               BANK_W        = 2,
    parameter int               CAS_LAT       = 3,
    parameter int               BURST_TYPE    = 0,
    parameter logic [2:0]       BURST_LEN     = 3'b111,
    parameter int               WRITE_BURST   = 0,
    parameter int               EMRS_EN       = 0,
    parameter logic [ROW_W-1:0] EMRS_VAL      = '0
) (
    input  logic               init_clk,
    input  logic               init_rst_n,
    sdram_init_param_if.master bus
);
    function automatic int cycles_of(input longint t_ns);
        longint v;
        v = (t_ns * longint'(1000) + longint'(CLK_PERIOD_PS) - longint'(1)) / longint'(CLK_PERIOD_PS);
        return (v < longint'(1)) ? 1 : int'(v);
    endfunction

    localparam int N_PWR   = cycles_of(longint'(T_POWERUP_NS));
    localparam int N_RP    = cycles_of(longint'(T_RP_NS));
    localparam int N_RFC   = cycles_of(longint'(T_RFC_NS));
    localparam int N_MRD   = T_MRD_CYC;
    localparam int N_MAX_A = (N_RP > N_RFC) ? N_RP : N_RFC;
    localparam int N_MAX   = (N_MAX_A > N_MRD) ? N_MAX_A : N_MRD;
    localparam int PWR_W   = $clog2(N_PWR + 1);
    localparam int TMR_W   = $clog2(N_MAX + 1);

    // Wait states exit when the timer reaches N-2: command cycle + (N-1) wait cycles = N.
    localparam logic [PWR_W-1:0] PWR_LAST = PWR_W'(N_PWR - 1);
    localparam logic [TMR_W-1:0] RP_LAST  = TMR_W'((N_RP  > 1) ? N_RP  - 2 : 0);
    localparam logic [TMR_W-1:0] RFC_LAST = TMR_W'((N_RFC > 1) ? N_RFC - 2 : 0);
    localparam logic [TMR_W-1:0] MRD_LAST = TMR_W'((N_MRD > 1) ? N_MRD - 2 : 0);
    localparam logic [3:0]       AR_LAST  = 4'(AR_NUM);
    localparam logic [3:0]       AR_BYP   = 4'(AR_NUM - 1);

    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_AR  = 4'b0001;
    localparam logic [3:0] CMD_MRS = 4'b0000;
    localparam logic [3:0] CMD_NOP = 4'b0111;

    localparam logic [ROW_W-1:0]  MRS_ADDR  = ROW_W'({1'(WRITE_BURST), 2'b00, 3'(CAS_LAT),
                                                      1'(BURST_TYPE), BURST_LEN});
    localparam logic [BANK_W-1:0] EMRS_BANK = BANK_W'(2'b10);

    if (AR_NUM < 1 || AR_NUM > 15) begin : g_bad_ar_num
        $error("sdram_init_param: AR_NUM must be within 1..15");
    end
    if (CAS_LAT != 2 && CAS_LAT != 3) begin : g_bad_cas_lat
        $error("sdram_init_param: CAS_LAT must be 2 or 3");
    end
    if (ROW_W < 11) begin : g_bad_row_w
        $error("sdram_init_param: ROW_W must be at least 11");
    end
    if (BANK_W < 2) begin : g_bad_bank_w
        $error("sdram_init_param: BANK_W must be at least 2");
    end
    if (T_MRD_CYC < 1) begin : g_bad_mrd
        $error("sdram_init_param: T_MRD_CYC must be at least 1");
    end

    typedef enum logic [3:0] {
        ST_PWRUP = 4'd0,
        ST_PRE   = 4'd1,
        ST_TRP   = 4'd2,
        ST_AR    = 4'd3,
        ST_TRFC  = 4'd4,
        ST_MRS   = 4'd5,
        ST_TMRD  = 4'd6,
        ST_EMRS  = 4'd7,
        ST_TEMRD = 4'd8,
        ST_DONE  = 4'd9
    } state_e;

    state_e             state_q, state_d;
    logic [PWR_W-1:0]   pwr_q, pwr_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [3:0]         ar_q, ar_d;
    logic [3:0]         cmd_q, cmd_d;
    logic [BANK_W-1:0]  bank_q, bank_d;
    logic [ROW_W-1:0]   addr_q, addr_d;
    logic               end_q, end_d;
    logic               busy_q, busy_d;

    state_e mrd_exit;
    assign mrd_exit = (EMRS_EN != 0) ? ST_EMRS : ST_DONE;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge init_clk or negedge init_rst_n) begin
        if (!init_rst_n) begin
            state_q <= ST_PWRUP;
            pwr_q   <= '0;
            tmr_q   <= '0;
            ar_q    <= '0;
            cmd_q   <= CMD_NOP;
            bank_q  <= '1;
            addr_q  <= '1;
            end_q   <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            pwr_q   <= pwr_d;
            tmr_q   <= tmr_d;
            ar_q    <= ar_d;
            cmd_q   <= cmd_d;
            bank_q  <= bank_d;
            addr_q  <= addr_d;
            end_q   <= end_d;
            busy_q  <= busy_d;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        pwr_d   = pwr_q;
        tmr_d   = '0;
        ar_d    = ar_q;
        unique case (state_q)
            ST_PWRUP: begin
                if (pwr_q == PWR_LAST) state_d = ST_PRE;
                else                   pwr_d   = pwr_q + 1'b1;
            end
            ST_PRE:   state_d = (N_RP > 1) ? ST_TRP : ST_AR;
            ST_TRP: begin
                tmr_d = tmr_q + 1'b1;
                if (tmr_q == RP_LAST) state_d = ST_AR;
            end
            ST_AR: begin
                ar_d = ar_q + 4'd1;
                if (N_RFC > 1) state_d = ST_TRFC;
                else           state_d = (ar_q == AR_BYP) ? ST_MRS : ST_AR;
            end
            ST_TRFC: begin
                tmr_d = tmr_q + 1'b1;
                if (tmr_q == RFC_LAST) state_d = (ar_q == AR_LAST) ? ST_MRS : ST_AR;
            end
            ST_MRS:   state_d = (N_MRD > 1) ? ST_TMRD : mrd_exit;
            ST_TMRD: begin
                tmr_d = tmr_q + 1'b1;
                if (tmr_q == MRD_LAST) state_d = mrd_exit;
            end
            ST_EMRS:  state_d = (N_MRD > 1) ? ST_TEMRD : ST_DONE;
            ST_TEMRD: begin
                tmr_d = tmr_q + 1'b1;
                if (tmr_q == MRD_LAST) state_d = ST_DONE;
            end
            ST_DONE:  if (bus.init_start) state_d = ST_PRE;
            default:  state_d = ST_PWRUP;
        endcase
        if (state_d == ST_PRE) ar_d = '0;
    end

    // Command values are decoded from the current state and land on the bus one cycle later.
    always_comb begin
        cmd_d  = CMD_NOP;
        bank_d = '1;
        addr_d = '1;
        end_d  = 1'b0;
        busy_d = 1'b1;
        case (state_q)
            ST_PRE:  cmd_d = CMD_PRE;
            ST_AR:   cmd_d = CMD_AR;
            ST_MRS: begin
                cmd_d  = CMD_MRS;
                bank_d = '0;
                addr_d = MRS_ADDR;
            end
            ST_EMRS: begin
                cmd_d  = CMD_MRS;
                bank_d = EMRS_BANK;
                addr_d = EMRS_VAL;
            end
            ST_DONE: begin
                end_d  = 1'b1;
                busy_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign bus.init_cmd  = cmd_q;
    assign bus.init_bank = bank_q;
    assign bus.init_addr = addr_q;
    assign bus.init_end  = end_q;
    assign bus.init_busy = busy_q;
endmodule

// File: doc/sdram_init_param.md
Name: sdram_init_param

Overview:
Parametrised SDRAM power-up initialisation sequencer. It is the successor to the fixed 100 MHz / 2-refresh initialiser.
- All timings are derived from clock period and nanosecond parameters.
- Address/bank widths, refresh count and mode-register fields are generic.
- Adds an optional extended-mode-register (EMRS) step, a re-initialisation request (skips the power-up wait), and a busy flag.
- Sits between the controller's command arbiter and the SDRAM pins; the arbiter muxes init_cmd/bank/addr onto the bus until init_end is high.

Parameters:
CLK_PERIOD_PS  10000  init_clk period in ps
T_POWERUP_NS  200000  power-up NOP wait
T_RP_NS  20  precharge-to-next-command time
T_RFC_NS  70  auto-refresh-to-next-command time
T_MRD_CYC  2  MRS/EMRS-to-next-command time, in cycles (>=1)
AR_NUM  2  number of auto-refresh commands, 1..15
ROW_W  13  address bus width, >=11
BANK_W  2  bank address width, >=2
CAS_LAT  3  CAS latency, 2 or 3
BURST_TYPE  0  0 = sequential, 1 = interleave
BURST_LEN  3'b111  mode-register A2..A0 code
WRITE_BURST  0  A9: 0 = burst write, 1 = single write
EMRS_EN  0  1 = issue EMRS after MRS
EMRS_VAL  0  ROW_W-bit EMRS address value

Ports:
init_clk  input  1  clock
init_rst_n  input  1  asynchronous active-low reset
init_start  input  1  re-init request, sampled only in DONE
init_busy  output  1  high while a sequence is in progress
init_end  output  1  high while initialised (DONE)
init_cmd  output  4  {CS#,RAS#,CAS#,WE#}
init_bank  output  BANK_W  bank address
init_addr  output  ROW_W  address

Behaviour:
- Reset is init_rst_n, asynchronous, active-low; clock is init_clk.
- Reset values (apply immediately on assertion, including mid-sequence):
  - init_cmd = NOP (4'b0111), init_bank = all ones, init_addr = all ones.
  - init_end = 0, init_busy = 1.
  - FSM = PWRUP, all counters = 0.
- Derived cycle counts, computed at elaboration:
  - N_x = ceil(T_x_NS*1000/CLK_PERIOD_PS), minimum 1, for x in {PWR, RP, RFC}.
  - N_MRD = T_MRD_CYC.
  - Counter widths are sized by $clog2 of the largest value.
  - Elaboration error if AR_NUM is outside 1..15, CAS_LAT is not 2 or 3, ROW_W < 11, or BANK_W < 2.
- Commands:
  - PRE = 0010, AR = 0001, MRS = 0000, NOP = 0111.
  - Every command is on the bus for exactly one cycle.
  - All other cycles drive NOP with bank and addr all ones; PRE therefore has A10 = 1 (all banks).
- MRS: bank = 0.
  - init_addr = {zeros(ROW_W-10), WRITE_BURST, 2'b00, CAS_LAT[2:0], BURST_TYPE, BURST_LEN}.
- EMRS: cmd = 0000, bank = {zeros(BANK_W-2), 2'b10}, addr = EMRS_VAL.
- Outputs are registered: a command is on the bus the cycle after the FSM enters its command state.
- States: PWRUP -> PRE -> TRP -> AR -> TRFC -> (AR | MRS) -> TMRD -> [EMRS -> TEMRD] -> DONE.
- Spacing rules (cycle 0 = first rising edge after reset release):
  - PRE on the bus in cycle N_PWR.
  - The next command follows exactly N_RP cycles after PRE, N_RFC cycles after each AR, and N_MRD cycles after MRS.
  - The EMRS-to-DONE spacing is also N_MRD.
- Refresh loop: the AR counter is cleared on entry to PRE and incremented per AR issued.
  - TRFC returns to AR until AR_NUM ARs have been issued, then goes to MRS.
  - With AR_NUM = 1 there is a single AR, followed by MRS.
- TMRD goes to EMRS if EMRS_EN = 1, else to DONE.
- init_end and init_busy:
  - init_end rises, and init_busy falls, in the cycle where the next command would otherwise be allowed: N_MRD after the last MRS/EMRS.
  - Both hold until reset or re-init.
- Power-up wait counter saturates and runs only once after reset.
- Re-init: init_start = 1 sampled in DONE at edge k.
  - FSM goes to PRE; init_end = 0 and init_busy = 1 from cycle k+1.
  - PRE on the bus in cycle k+1; the rest follows the normal spacing.
  - The power-up wait is skipped.
- init_start in any state other than DONE is ignored; it is not queued.
- Illegal or unused FSM encodings return to PWRUP.

Test Plan:
1. Defaults, release reset -> NOP only until cycle 19999; PRE @20000; AR @20002 and @20009; MRS @20016 with addr = 13'h0037, bank = 0; init_end = 1 and init_busy = 0 from cycle 20018; exactly two AR commands in total.
2. Rounding: T_RFC_NS = 63, AR_NUM = 4, T_POWERUP_NS = 100 -> PRE @10; AR @12, 19, 26, 33; MRS @40; init_end @42.
3. EMRS_EN = 1, EMRS_VAL = 13'h0020 -> EMRS @(MRS+2) with bank = 2'b10, addr = 13'h0020; init_end @(MRS+4); MRS field check with CAS_LAT = 2, BURST_LEN = 3'b011, WRITE_BURST = 1 -> addr = 13'h0223.
4. Re-init: pulse init_start for 1 cycle in DONE at edge k -> init_end low and PRE on bus @k+1; full AR/MRS sequence follows with no power-up wait; init_end high again @k+19 (defaults).
5. init_start held high during the power-up wait and during TRFC -> no effect on command timing; sequence identical to scenario 1.
6. Assert reset between the two AR commands -> outputs immediately NOP / all ones, init_end = 0; after release the full sequence repeats from cycle 0 with the 20000-cycle wait.
